// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with a three-state request FSM.
//
// Holds the program counter, issues instruction-memory requests, captures
// the returned word and hands {pc, inst} to decode. Exceptions/ERET from
// writeback and taken jumps/branches from decode redirect the pc.
//
// Optional feature (macro REDIRECT_HOLD_EN): a taken jbr_bus redirect seen
// without an accompanying pc advance is latched and applied at the next
// advance. Without the macro such a redirect is ignored.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset
//   IF_valid   in   1   fetch stage holds a valid slot
//   next_fetch in   1   decode accepted current instruction, advance pc
//   jbr_bus    in  33   {jbr_taken, jbr_target}
//   exc_bus    in  33   {exc_valid, exc_pc}
//   inst_req   out  1   instruction-memory request
//   inst_addr  out 32   request address (= pc)
//   inst_ack   in   1   request accepted, inst_rdata valid this cycle
//   inst_rdata in  32   returned instruction word
//   IF_over    out  1   instruction captured, ready for decode
//   IF_ID_bus  out 64   {pc, inst}
//   IF_pc      out 32   display copy of pc
//   IF_inst    out 32   display copy of inst
module fetch_stage #(
  parameter logic [31:0] STARTADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_valid,
  input  logic        next_fetch,
  input  logic [32:0] jbr_bus,
  input  logic [32:0] exc_bus,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        IF_over,
  output logic [63:0] IF_ID_bus,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic        r_discard, w_discard_nxt;
  logic [31:0] w_next_pc;
  logic        w_advance;

  logic        w_jbr_taken, w_exc_valid;
  logic [31:0] w_jbr_target, w_exc_pc;

  assign w_jbr_taken  = jbr_bus[32];
  assign w_jbr_target = jbr_bus[31:0];
  assign w_exc_valid  = exc_bus[32];
  assign w_exc_pc     = exc_bus[31:0];

  // pc advances only when decode takes the captured instruction
  assign w_advance = (r_state == DONE) && next_fetch;

`ifdef REDIRECT_HOLD_EN
  logic        r_pend_valid;
  logic [31:0] r_pend_target;

  // A live redirect overrides an older pending one; exceptions flush it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else if (w_exc_valid || w_advance) begin
      r_pend_valid  <= 1'b0;
    end else if (w_jbr_taken) begin
      r_pend_valid  <= 1'b1;
      r_pend_target <= w_jbr_target;
    end
  end

  always_comb begin
    if (w_exc_valid)       w_next_pc = w_exc_pc;
    else if (w_jbr_taken)  w_next_pc = w_jbr_target;
    else if (r_pend_valid) w_next_pc = r_pend_target;
    else                   w_next_pc = r_pc + 32'd4;
  end
`else
  always_comb begin
    if (w_exc_valid)      w_next_pc = w_exc_pc;
    else if (w_jbr_taken) w_next_pc = w_jbr_target;
    else                  w_next_pc = r_pc + 32'd4;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pc      <= STARTADDR;
      r_inst    <= '0;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_discard_nxt = r_discard;
    inst_req      = 1'b0;
    IF_over       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_exc_valid) begin
          w_pc_nxt    = w_exc_pc;
          w_state_nxt = REQ;
        end else if (IF_valid) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        inst_req = 1'b1;
        if (w_exc_valid) begin
          // The old request stays outstanding; its ack (if not this cycle)
          // must be dropped, hence discard unless the ack is here now.
          w_pc_nxt      = w_exc_pc;
          w_discard_nxt = ~inst_ack;
        end else if (inst_ack) begin
          if (r_discard) begin
            w_discard_nxt = 1'b0;
          end else begin
            w_inst_nxt  = inst_rdata;
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        IF_over = IF_valid;
        if (w_exc_valid) begin
          w_pc_nxt    = w_exc_pc;
          w_state_nxt = REQ;
        end else if (next_fetch) begin
          w_pc_nxt    = w_next_pc;
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign inst_addr = r_pc;
  assign IF_ID_bus = {r_pc, r_inst};
  assign IF_pc     = r_pc;
  assign IF_inst   = r_inst;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        IF_valid;
  logic        next_fetch;
  logic [32:0] jbr_bus;
  logic [32:0] exc_bus;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        IF_over;
  logic [63:0] IF_ID_bus;
  logic [31:0] IF_pc;
  logic [31:0] IF_inst;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.STARTADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .IF_valid   (IF_valid),
    .next_fetch (next_fetch),
    .jbr_bus    (jbr_bus),
    .exc_bus    (exc_bus),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_ack   (inst_ack),
    .inst_rdata (inst_rdata),
    .IF_over    (IF_over),
    .IF_ID_bus  (IF_ID_bus),
    .IF_pc      (IF_pc),
    .IF_inst    (IF_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; inputs set after this take effect at the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From IDLE or DONE: redirect via exception to addr, then ack with word.
  // Leaves the DUT in DONE with pc=addr.
  task automatic goto_done(input logic [31:0] addr, input logic [31:0] word);
    exc_bus = {1'b1, addr};
    tick();
    exc_bus    = '0;
    inst_ack   = 1'b1;
    inst_rdata = word;
    tick();
    inst_ack   = 1'b0;
    inst_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (inst_req !== 1'b0) begin
      errors++; $display("FAIL reset_inst_req got %0b want 0", inst_req);
    end
    checks++;
    if (inst_addr !== 32'h0) begin
      errors++; $display("FAIL reset_inst_addr got %h want 00000000", inst_addr);
    end
    checks++;
    if (IF_over !== 1'b0) begin
      errors++; $display("FAIL reset_IF_over got %0b want 0", IF_over);
    end
    checks++;
    if (IF_ID_bus !== 64'h0) begin
      errors++; $display("FAIL reset_IF_ID_bus got %h want 0", IF_ID_bus);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_fetch();
    IF_valid = 1'b1;
    tick();  // IDLE -> REQ
    checks++;
    if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
      errors++; $display("FAIL first_req got req=%0b addr=%h want req=1 addr=00000000", inst_req, inst_addr);
    end
    tick();
    tick();  // third REQ cycle now
    inst_ack   = 1'b1;
    inst_rdata = 32'h2402_0001;
    #1;
    checks++;
    if (IF_over !== 1'b0) begin
      errors++; $display("FAIL first_over_early got %0b want 0", IF_over);
    end
    tick();
    inst_ack   = 1'b0;
    inst_rdata = '0;
    checks++;
    if (IF_over !== 1'b1 || inst_req !== 1'b0) begin
      errors++; $display("FAIL first_over got over=%0b req=%0b want over=1 req=0", IF_over, inst_req);
    end
    checks++;
    if (IF_ID_bus !== {32'h0, 32'h2402_0001}) begin
      errors++; $display("FAIL first_bus got %h want 0000000024020001", IF_ID_bus);
    end
    checks++;
    if (IF_pc !== 32'h0 || IF_inst !== 32'h2402_0001) begin
      errors++; $display("FAIL first_display got pc=%h inst=%h want 00000000 24020001", IF_pc, IF_inst);
    end
  endtask

  task automatic test_branch();
    goto_done(32'h100, 32'hAAAA_0001);
    checks++;
    if (IF_ID_bus !== {32'h100, 32'hAAAA_0001}) begin
      errors++; $display("FAIL branch_setup got %h want 00000100aaaa0001", IF_ID_bus);
    end
    next_fetch = 1'b1;
    jbr_bus    = {1'b1, 32'h200};
    tick();
    next_fetch = 1'b0;
    jbr_bus    = '0;
    checks++;
    if (inst_addr !== 32'h200 || inst_req !== 1'b1) begin
      errors++; $display("FAIL branch_taken got addr=%h req=%0b want 00000200 1", inst_addr, inst_req);
    end
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    goto_done(32'h100, 32'hAAAA_0002);
    next_fetch = 1'b1;
    jbr_bus    = {1'b0, 32'h200};
    tick();
    next_fetch = 1'b0;
    jbr_bus    = '0;
    checks++;
    if (inst_addr !== 32'h104) begin
      errors++; $display("FAIL branch_not_taken got %h want 00000104", inst_addr);
    end
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
  endtask

  task automatic test_wrap();
    goto_done(32'hFFFF_FFFC, 32'h1);
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    checks++;
    if (inst_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got %h want 00000000", inst_addr);
    end
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    // unaligned low bits ride through the increment
    goto_done(32'h0000_0103, 32'h2);
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    checks++;
    if (inst_addr !== 32'h0000_0107) begin
      errors++; $display("FAIL low_bits got %h want 00000107", inst_addr);
    end
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
  endtask

  task automatic test_exception();
    goto_done(32'h3C, 32'h3);
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    checks++;
    if (inst_addr !== 32'h40 || inst_req !== 1'b1) begin
      errors++; $display("FAIL exc_pre got addr=%h req=%0b want 00000040 1", inst_addr, inst_req);
    end
    exc_bus = {1'b1, 32'h380};
    tick();
    exc_bus = '0;
    checks++;
    if (inst_addr !== 32'h380 || inst_req !== 1'b1) begin
      errors++; $display("FAIL exc_redirect got addr=%h req=%0b want 00000380 1", inst_addr, inst_req);
    end
    inst_ack   = 1'b1;
    inst_rdata = 32'hDEAD_BEEF;
    tick();
    inst_ack   = 1'b0;
    inst_rdata = '0;
    checks++;
    if (IF_over !== 1'b0 || inst_req !== 1'b1 || IF_inst === 32'hDEAD_BEEF) begin
      errors++; $display("FAIL exc_drop got over=%0b req=%0b inst=%h want over=0 req=1 inst!=deadbeef", IF_over, inst_req, IF_inst);
    end
    inst_ack   = 1'b1;
    inst_rdata = 32'h1111_2222;
    tick();
    inst_ack   = 1'b0;
    inst_rdata = '0;
    checks++;
    if (IF_over !== 1'b1 || IF_ID_bus !== {32'h380, 32'h1111_2222}) begin
      errors++; $display("FAIL exc_refetch got over=%0b bus=%h want 1 0000038011112222", IF_over, IF_ID_bus);
    end
    // exception coincident with ack: data dropped, no lingering discard
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    exc_bus    = {1'b1, 32'h600};
    inst_ack   = 1'b1;
    inst_rdata = 32'hBAD0_0000;
    tick();
    exc_bus    = '0;
    inst_ack   = 1'b0;
    inst_rdata = '0;
    checks++;
    if (IF_over !== 1'b0 || inst_addr !== 32'h600 || inst_req !== 1'b1) begin
      errors++; $display("FAIL exc_coincident got over=%0b addr=%h req=%0b want 0 00000600 1", IF_over, inst_addr, inst_req);
    end
    inst_ack   = 1'b1;
    inst_rdata = 32'h3333_4444;
    tick();
    inst_ack   = 1'b0;
    inst_rdata = '0;
    checks++;
    if (IF_over !== 1'b1 || IF_ID_bus !== {32'h600, 32'h3333_4444}) begin
      errors++; $display("FAIL exc_coincident_fetch got over=%0b bus=%h want 1 0000060033334444", IF_over, IF_ID_bus);
    end
  endtask

  task automatic test_reset_mid_req();
    next_fetch = 1'b1;
    tick();  // DONE -> REQ
    next_fetch = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (inst_req !== 1'b0 || IF_over !== 1'b0 || inst_addr !== 32'h0 || IF_inst !== 32'h0) begin
      errors++; $display("FAIL rst_mid got req=%0b over=%0b addr=%h inst=%h want 0 0 00000000 00000000", inst_req, IF_over, inst_addr, IF_inst);
    end
    inst_ack   = 1'b1;
    inst_rdata = 32'h5555_6666;
    tick();
    inst_ack   = 1'b0;
    inst_rdata = '0;
    checks++;
    if (IF_over !== 1'b0 || IF_inst !== 32'h0 || inst_addr !== 32'h0) begin
      errors++; $display("FAIL late_ack got over=%0b inst=%h addr=%h want 0 00000000 00000000", IF_over, IF_inst, inst_addr);
    end
    // complete the fresh request so the next test starts in DONE
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
  endtask

  task automatic test_redirect_hold();
    logic [31:0] exp_addr;
`ifdef REDIRECT_HOLD_EN
    exp_addr = 32'h500;
`else
    exp_addr = 32'h1008;
`endif
    goto_done(32'h1000, 32'h7);
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    jbr_bus = {1'b1, 32'h500};
    tick();
    jbr_bus  = '0;
    inst_ack = 1'b1;
    tick();
    inst_ack = 1'b0;
    checks++;
    if (IF_pc !== 32'h1004 || IF_over !== 1'b1) begin
      errors++; $display("FAIL hold_done got pc=%h over=%0b want 00001004 1", IF_pc, IF_over);
    end
    next_fetch = 1'b1;
    tick();
    next_fetch = 1'b0;
    checks++;
    if (inst_addr !== exp_addr) begin
      errors++; $display("FAIL hold_redirect got %h want %h", inst_addr, exp_addr);
    end
  endtask

  initial begin
    rst        = 1'b0;
    IF_valid   = 1'b0;
    next_fetch = 1'b0;
    jbr_bus    = '0;
    exc_bus    = '0;
    inst_ack   = 1'b0;
    inst_rdata = '0;
    test_reset();
    test_first_fetch();
    test_branch();
    test_wrap();
    test_exception();
    test_reset_mid_req();
    test_redirect_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
